stack_driver: RTL and testbench

Command initiator for the `STACK` unit. It accepts one command at a time from a client over a valid/ready interface and drives the stack's transition-signalled request line (`rdy_in`). It waits for a transition on the stack's `ack`, then returns `dataout`/`esito` to the client, flagging a timeout if no acknowledge arrives. It sits between control logic (or a bus bridge) and the stack, and it is the only master of the stack's request side.

---
 rtl/stack_pkg.sv | 26 ++
 rtl/toggle_edge_det.sv | 24 ++
 rtl/stack_driver.sv | 142 ++++++++++++++
 tb/tb_stack_driver.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the STACK unit and its command driver:
// op-codes, sizing constants and the driver FSM state type.
package stack_pkg;

    localparam int DATA_W      = 32;
    localparam int N_W         = 10;
    localparam int OP_W        = 3;
    localparam int STACK_DEPTH = 1024;

    localparam logic [OP_W-1:0] OP_PUSH = 3'd0;
    localparam logic [OP_W-1:0] OP_POP  = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd3;
    localparam logic [OP_W-1:0] OP_AVG  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } drv_state_e;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_AVG);
    endfunction

endpackage

// File: rtl/toggle_edge_det.sv
// Detects level changes on a transition-signalled handshake line.
// Emits a one-cycle pulse whenever the input differs from its registered copy.
module toggle_edge_det (
    input  logic clock,
    input  logic level,
    output logic pulse
);

    logic level_d;
    logic level_q;

    // The copy follows the line every cycle, reset included, so a standing
    // level present while reset is held is never mistaken for a transition.
    always_comb begin
        level_d = level;
    end

    always_ff @(posedge clock) begin
        level_q <= level_d;
    end

    assign pulse = level ^ level_q;

endmodule

// File: rtl/stack_driver.sv
// Command initiator for the STACK unit: one valid/ready command in, one
// toggle request to the stack, one held result (or timeout) back out.
module stack_driver
    import stack_pkg::*;
#(
    parameter int DATA_W  = stack_pkg::DATA_W,
    parameter int N_W     = stack_pkg::N_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic [N_W-1:0]           cmd_n,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [DATA_W-1:0] res_data,
    output logic                     res_esito,
    output logic                     res_timeout,
    output logic                     stk_rdy,
    output logic [2:0]               stk_op,
    output logic [DATA_W-1:0]        stk_datain,
    output logic [N_W-1:0]           stk_n,
    input  logic [DATA_W-1:0]        stk_dataout,
    input  logic                     stk_esito,
    input  logic                     stk_ack
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    drv_state_e          state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_esito_q, res_esito_d;
    logic                res_timeout_q, res_timeout_d;
    logic                stk_rdy_q, stk_rdy_d;
    logic [2:0]          stk_op_q, stk_op_d;
    logic [DATA_W-1:0]   stk_datain_q, stk_datain_d;
    logic [N_W-1:0]      stk_n_q, stk_n_d;
    logic                ack_pulse;

    toggle_edge_det u_ack_det (
        .clock (clock),
        .level (stk_ack),
        .pulse (ack_pulse)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        res_data_d    = res_data_q;
        res_esito_d   = res_esito_q;
        res_timeout_d = res_timeout_q;
        stk_rdy_d     = stk_rdy_q;
        stk_op_d      = stk_op_q;
        stk_datain_d  = stk_datain_q;
        stk_n_d       = stk_n_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (op_is_legal(cmd_op)) begin
                        stk_op_d     = cmd_op;
                        stk_datain_d = cmd_data;
                        stk_n_d      = cmd_n;
                        stk_rdy_d    = ~stk_rdy_q;
                        timer_d      = '0;
                        state_d      = ST_WAIT;
                    end else begin
                        res_data_d    = '0;
                        res_esito_d   = 1'b0;
                        res_timeout_d = 1'b0;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // Saturating at the last count keeps the timer from wrapping.
                if (timer_q != TIMER_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
                if (ack_pulse) begin
                    res_data_d    = stk_dataout;
                    res_esito_d   = stk_esito;
                    res_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    res_data_d    = '0;
                    res_esito_d   = 1'b0;
                    res_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            res_data_q    <= '0;
            res_esito_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            stk_rdy_q     <= 1'b0;
            stk_op_q      <= '0;
            stk_datain_q  <= '0;
            stk_n_q       <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            res_data_q    <= res_data_d;
            res_esito_q   <= res_esito_d;
            res_timeout_q <= res_timeout_d;
            stk_rdy_q     <= stk_rdy_d;
            stk_op_q      <= stk_op_d;
            stk_datain_q  <= stk_datain_d;
            stk_n_q       <= stk_n_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_RESP);
    assign res_data    = res_data_q;
    assign res_esito   = res_esito_q;
    assign res_timeout = res_timeout_q;
    assign stk_rdy     = stk_rdy_q;
    assign stk_op      = stk_op_q;
    assign stk_datain  = stk_datain_q;
    assign stk_n       = stk_n_q;

endmodule

// File: tb/tb_stack_driver.sv
// Scoreboard bench for stack_driver against a behavioural toggle-handshake
// stack; expected results are hand-computed and queued at issue time.
module tb_stack_driver;

    typedef struct {
        logic [31:0] data;
        logic        esito;
        logic        timeout;
        logic        chk_data;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [2:0]         cmd_op = 3'd0;
    logic [31:0]        cmd_data = 32'd0;
    logic [9:0]         cmd_n = 10'd0;
    logic               res_valid;
    logic               res_ready = 1'b1;
    logic signed [31:0] res_data;
    logic               res_esito;
    logic               res_timeout;
    logic               stk_rdy;
    logic [2:0]         stk_op;
    logic [31:0]        stk_datain;
    logic [9:0]         stk_n;
    logic [31:0]        stk_dataout = 32'd0;
    logic               stk_esito = 1'b0;
    logic               stk_ack = 1'b0;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    logic exp_rdy = 1'b0;

    logic               rdy_seen = 1'b0;
    logic               pending_late = 1'b0;
    bit                 silent = 1'b0;
    int                 rdy_toggles = 0;
    logic [31:0]        mem [0:1023];
    int                 sp = 0;
    logic [31:0]        r_val;
    logic               e_val;
    logic signed [63:0] acc;

    stack_driver #(
        .DATA_W  (32),
        .N_W     (10),
        .TIMEOUT (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_n       (cmd_n),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_esito   (res_esito),
        .res_timeout (res_timeout),
        .stk_rdy     (stk_rdy),
        .stk_op      (stk_op),
        .stk_datain  (stk_datain),
        .stk_n       (stk_n),
        .stk_dataout (stk_dataout),
        .stk_esito   (stk_esito),
        .stk_ack     (stk_ack)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Behavioural stack: answers each request level change in the same edge it
    // is seen; when silent it stays quiet and fires a late ack once released.
    always @(posedge clock) begin
        if (reset) begin
            sp = 0;
            rdy_seen     <= 1'b0;
            stk_ack      <= 1'b0;
            stk_dataout  <= 32'd0;
            stk_esito    <= 1'b0;
            pending_late <= 1'b0;
        end else if (stk_rdy !== rdy_seen) begin
            rdy_seen <= stk_rdy;
            rdy_toggles++;
            if (silent) begin
                pending_late <= 1'b1;
            end else begin
                r_val = 32'd0;
                e_val = 1'b0;
                case (stk_op)
                    3'd0: if (sp < 1024) begin mem[sp] = stk_datain; sp++; e_val = 1'b1; end
                    3'd1: if (sp > 0) begin sp--; r_val = mem[sp]; e_val = 1'b1; end
                    3'd2: if (sp >= 2) begin r_val = mem[sp-1] + mem[sp-2]; e_val = 1'b1; end
                    3'd3: if (sp >= 2) begin r_val = mem[sp-2] - mem[sp-1]; e_val = 1'b1; end
                    3'd4: if (stk_n != 10'd0 && sp >= int'(stk_n)) begin
                        acc = 64'sd0;
                        for (int k = 1; k <= int'(stk_n); k++) acc += 64'(signed'(mem[sp-k]));
                        r_val = 32'(acc / $signed({54'd0, stk_n}));
                        e_val = 1'b1;
                    end
                    default: e_val = 1'b0;
                endcase
                stk_dataout <= r_val;
                stk_esito   <= e_val;
                stk_ack     <= ~stk_ack;
            end
        end else if (pending_late && !silent) begin
            pending_late <= 1'b0;
            stk_dataout  <= 32'hDEAD_BEEF;
            stk_esito    <= 1'b1;
            stk_ack      <= ~stk_ack;
        end
    end

    // Monitor samples just after the falling edge, once stimulus has settled.
    always begin
        exp_t x;
        @(negedge clock);
        #1;
        if (!reset && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got res_valid=1, expected no result");
            end else begin
                x = sb_q.pop_front();
                checkOutput("res_esito", 32'(res_esito), 32'(x.esito));
                checkOutput("res_timeout", 32'(res_timeout), 32'(x.timeout));
                if (x.chk_data) checkOutput("res_data", res_data, x.data);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] data, input logic [9:0] n,
                                 input bit expect_result, input logic [31:0] ed, input logic ee,
                                 input logic et, input logic cd);
        exp_t x;
        int   w;
        if (expect_result) begin
            x.data = ed; x.esito = ee; x.timeout = et; x.chk_data = cd;
            sb_q.push_back(x);
        end
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_n     = n;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_accept: got cmd_ready=0 for 100 cycles, expected 1");
        end
        if (op <= 3'd4) exp_rdy = ~exp_rdy;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_wait: got res_valid=0 for 100 cycles, expected 1");
        end
        if (res_ready) @(negedge clock);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int t0;
        int bad;

        repeat (3) @(negedge clock);
        reset = 1'b0;

        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_data", res_data, 32'd0);
        checkOutput("rst_res_esito", 32'(res_esito), 32'd0);
        checkOutput("rst_res_timeout", 32'(res_timeout), 32'd0);
        checkOutput("rst_stk_rdy", 32'(stk_rdy), 32'd0);
        checkOutput("rst_stk_op", 32'(stk_op), 32'd0);
        checkOutput("rst_stk_datain", stk_datain, 32'd0);
        checkOutput("rst_stk_n", 32'(stk_n), 32'd0);

        $display("[TB] push/pop");
        t0 = rdy_toggles;
        applyStimulus(3'd0, 32'd1023, 10'd0, 1, 32'd0, 1'b1, 1'b0, 1'b0);
        waitResult(lat);
        checkOutput("push_latency", 32'(lat), 32'd3);
        checkOutput("push_stk_datain", stk_datain, 32'd1023);
        applyStimulus(3'd1, 32'd0, 10'd0, 1, 32'd1023, 1'b1, 1'b0, 1'b1);
        waitResult(lat);
        checkOutput("pop_stk_op", 32'(stk_op), 32'd1);
        checkOutput("pushpop_toggles", 32'(rdy_toggles - t0), 32'd2);
        checkOutput("pushpop_stk_rdy", 32'(stk_rdy), 32'(exp_rdy));

        $display("[TB] arithmetic");
        applyStimulus(3'd0, 32'd500, 10'd0, 1, 32'd0, 1'b1, 1'b0, 1'b0);
        waitResult(lat);
        applyStimulus(3'd0, 32'd750, 10'd0, 1, 32'd0, 1'b1, 1'b0, 1'b0);
        waitResult(lat);
        applyStimulus(3'd2, 32'd0, 10'd0, 1, 32'd1250, 1'b1, 1'b0, 1'b1);
        waitResult(lat);
        applyStimulus(3'd0, 32'd1200, 10'd0, 1, 32'd0, 1'b1, 1'b0, 1'b0);
        waitResult(lat);
        applyStimulus(3'd0, 32'd300, 10'd0, 1, 32'd0, 1'b1, 1'b0, 1'b0);
        waitResult(lat);
        applyStimulus(3'd3, 32'd0, 10'd0, 1, 32'd900, 1'b1, 1'b0, 1'b1);
        waitResult(lat);
        applyStimulus(3'd4, 32'd0, 10'd4, 1, 32'd687, 1'b1, 1'b0, 1'b1);
        waitResult(lat);
        checkOutput("avg_stk_n", 32'(stk_n), 32'd4);

        $display("[TB] illegal op");
        t0 = rdy_toggles;
        applyStimulus(3'd6, 32'd77, 10'd3, 1, 32'd0, 1'b0, 1'b0, 1'b1);
        waitResult(lat);
        checkOutput("illegal_latency", 32'(lat), 32'd1);
        checkOutput("illegal_stk_rdy", 32'(stk_rdy), 32'(exp_rdy));
        checkOutput("illegal_toggles", 32'(rdy_toggles - t0), 32'd0);

        $display("[TB] backpressure");
        applyStimulus(3'd0, 32'd7, 10'd0, 1, 32'd0, 1'b1, 1'b0, 1'b0);
        waitResult(lat);
        res_ready = 1'b0;
        applyStimulus(3'd1, 32'd0, 10'd0, 1, 32'd7, 1'b1, 1'b0, 1'b1);
        waitResult(lat);
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_data  = 32'd55;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
            checkOutput("bp_res_data", res_data, 32'd7);
            checkOutput("bp_res_esito", 32'(res_esito), 32'd1);
            checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clock);

        $display("[TB] timeout");
        silent = 1'b1;
        applyStimulus(3'd0, 32'd99, 10'd0, 1, 32'd0, 1'b0, 1'b1, 1'b1);
        waitResult(lat);
        checkOutput("timeout_latency", 32'(lat), 32'd17);
        silent = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clock);
            if (res_valid) bad++;
        end
        checkOutput("late_ack_no_result", 32'(bad), 32'd0);
        checkOutput("late_ack_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("[TB] reset mid-wait");
        silent = 1'b1;
        applyStimulus(3'd0, 32'd5, 10'd2, 0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        silent  = 1'b0;
        exp_rdy = 1'b0;
        checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("mid_rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("mid_rst_stk_rdy", 32'(stk_rdy), 32'd0);
        checkOutput("mid_rst_stk_op", 32'(stk_op), 32'd0);
        checkOutput("mid_rst_stk_datain", stk_datain, 32'd0);
        checkOutput("mid_rst_stk_n", 32'(stk_n), 32'd0);
        checkOutput("mid_rst_res_timeout", 32'(res_timeout), 32'd0);
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (res_valid) bad++;
        end
        checkOutput("mid_rst_no_result", 32'(bad), 32'd0);

        $display("[TB] stack boundaries");
        applyStimulus(3'd1, 32'd0, 10'd0, 1, 32'd0, 1'b0, 1'b0, 1'b1);
        waitResult(lat);
        for (int i = 0; i < 1025; i++) begin
            applyStimulus(3'd0, 32'(i), 10'd0, 1, 32'd0, (i < 1024), 1'b0, 1'b0);
            waitResult(lat);
        end
        for (int i = 0; i < 1025; i++) begin
            applyStimulus(3'd1, 32'd0, 10'd0, 1, (i < 1024) ? 32'(1023 - i) : 32'd0,
                          (i < 1024), 1'b0, 1'b1);
            waitResult(lat);
        end
        checkOutput("final_stk_rdy", 32'(stk_rdy), 32'(exp_rdy));

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
